// File: rtl/maxpool2d_if.sv
// Bus bundle for the 2x2 max-pooling stage: start/busy/done handshake plus the
// full input and output feature maps. The master side starts runs and supplies
// the input map; the slave side (the pooling block) returns the pooled map.
interface maxpool2d_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned IMG_SIZE   = 28,
  parameter int unsigned POOL       = 2
);
  localparam int unsigned OUT_SIZE = IMG_SIZE / POOL;

  logic                         start;
  logic                         busy;
  logic                         done;
  logic signed [DATA_WIDTH-1:0] in_feature  [0:CHANNELS-1][0:IMG_SIZE-1][0:IMG_SIZE-1];
  logic signed [DATA_WIDTH-1:0] out_feature [0:CHANNELS-1][0:OUT_SIZE-1][0:OUT_SIZE-1];

  modport master (
    output start,
    output in_feature,
    input  busy,
    input  done,
    input  out_feature
  );

  modport slave (
    input  start,
    input  in_feature,
    output busy,
    output done,
    output out_feature
  );
endinterface

// File: rtl/maxpool2d.sv
// Fixed-point max-pooling stage. Walks every POOL x POOL window of every channel,
// one input element per clock, and writes the window maximum into the registered
// output map. Optional fused ReLU is enabled by defining MAXPOOL_RELU_EN: the
// window load clamps negatives to zero so every output is max(0, window max).
module maxpool2d #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned IMG_SIZE   = 28,
  parameter int unsigned POOL       = 2
) (
  input logic         clk,
  input logic         reset,
  maxpool2d_if.slave  bus
);
  localparam int unsigned OUT_SIZE = IMG_SIZE / POOL;
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned OW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int unsigned KW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int unsigned RW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

  localparam logic [CW-1:0] CMax = CW'(CHANNELS - 1);
  localparam logic [OW-1:0] OMax = OW'(OUT_SIZE - 1);
  localparam logic [KW-1:0] KMax = KW'(POOL - 1);

  typedef enum logic [1:0] {StIdle, StScan, StFinish} state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                ch_q, ch_d;
  logic [OW-1:0]                orow_q, orow_d;
  logic [OW-1:0]                ocol_q, ocol_d;
  logic [KW-1:0]                ki_q, ki_d;
  logic [KW-1:0]                kj_q, kj_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic                         busy_q, done_q;

  logic [RW-1:0]                row_idx, col_idx;
  logic signed [DATA_WIDTH-1:0] elem, load_val, max_next;
  logic                         first_k, last_k, wr_en;

  // Element addressing, window max update and output write enable.
  always_comb begin
    row_idx = RW'(32'(orow_q) * POOL + 32'(ki_q));
    col_idx = RW'(32'(ocol_q) * POOL + 32'(kj_q));
    elem    = bus.in_feature[ch_q][row_idx][col_idx];
    first_k = (ki_q == '0) && (kj_q == '0);
    last_k  = (ki_q == KMax) && (kj_q == KMax);
`ifdef MAXPOOL_RELU_EN
    load_val = elem[DATA_WIDTH-1] ? '0 : elem;
`else
    load_val = elem;
`endif
    max_next = first_k ? load_val : ((elem > max_q) ? elem : max_q);
    // The final element of a window goes straight to the output, bypassing max_q.
    wr_en    = (state_q == StScan) && last_k;
  end

  // Next-state logic: counter chain kj -> ki -> ocol -> orow -> ch.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    ki_d    = ki_q;
    kj_d    = kj_q;
    max_d   = max_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ch_d    = '0;
          orow_d  = '0;
          ocol_d  = '0;
          ki_d    = '0;
          kj_d    = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        max_d = max_next;
        if (kj_q != KMax) begin
          kj_d = kj_q + 1'b1;
        end else begin
          kj_d = '0;
          if (ki_q != KMax) begin
            ki_d = ki_q + 1'b1;
          end else begin
            ki_d = '0;
            if (ocol_q != OMax) begin
              ocol_d = ocol_q + 1'b1;
            end else begin
              ocol_d = '0;
              if (orow_q != OMax) begin
                orow_d = orow_q + 1'b1;
              end else begin
                orow_d = '0;
                if (ch_q != CMax) begin
                  ch_d = ch_q + 1'b1;
                end else begin
                  ch_d    = '0;
                  state_d = StFinish;
                end
              end
            end
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters, status flags and the registered output map.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      ch_q            <= '0;
      orow_q          <= '0;
      ocol_q          <= '0;
      ki_q            <= '0;
      kj_q            <= '0;
      max_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      bus.out_feature <= '{default: '0};
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      ki_q    <= ki_d;
      kj_q    <= kj_d;
      max_q   <= max_d;
      // busy spans the scan edges; done marks the single FINISH edge.
      busy_q  <= (state_q == StScan);
      done_q  <= (state_q == StFinish);
      if (wr_en) begin
        bus.out_feature[ch_q][orow_q][ocol_q] <= max_next;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_maxpool2d.sv
// Bench for maxpool2d: three instances (2ch 4x4, default 8ch 28x28, 2ch 5x5).
// Stimulus pushes expected outputs and latency into per-instance queues; a
// monitor pops and compares whenever an instance pulses done.
module tb_maxpool2d;
`ifdef MAXPOOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    string       name;
    int          ch;
    int          r;
    int          c;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   t0_a, t0_b, t0_c;
  exp_t exp_a[$], exp_b[$], exp_c[$];
  int   lat_a[$], lat_b[$], lat_c[$];
  logic [15:0] p1 [0:31];

  maxpool2d_if #(.CHANNELS(2), .IMG_SIZE(4)) if_a ();
  maxpool2d_if                                if_b ();
  maxpool2d_if #(.CHANNELS(2), .IMG_SIZE(5)) if_c ();

  maxpool2d #(.CHANNELS(2), .IMG_SIZE(4)) dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
  maxpool2d                                dut_b (.clk(clk), .reset(rst_b), .bus(if_b));
  maxpool2d #(.CHANNELS(2), .IMG_SIZE(5)) dut_c (.clk(clk), .reset(rst_c), .bus(if_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic exp_t mk(input string n, input int ch, input int r, input int c,
                              input logic [15:0] v);
    exp_t e;
    e.name = n; e.ch = ch; e.r = r; e.c = c; e.val = v;
    return e;
  endfunction

  // Pattern 1 expectations (hand-computed window maxima).
  task automatic push_p1(input string tag);
    exp_a.push_back(mk({tag, "_c0_00"}, 0, 0, 0, 16'h0280));
    exp_a.push_back(mk({tag, "_c0_01"}, 0, 0, 1, RELU ? 16'h0000 : 16'hFFFF));
    exp_a.push_back(mk({tag, "_c0_10"}, 0, 1, 0, 16'h0006));
    exp_a.push_back(mk({tag, "_c0_11"}, 0, 1, 1, 16'h7FFF));
    exp_a.push_back(mk({tag, "_c1_00"}, 1, 0, 0, RELU ? 16'h0000 : 16'h8000));
    exp_a.push_back(mk({tag, "_c1_01"}, 1, 0, 1, 16'h0030));
    exp_a.push_back(mk({tag, "_c1_10"}, 1, 1, 0, 16'h0050));
    exp_a.push_back(mk({tag, "_c1_11"}, 1, 1, 1, RELU ? 16'h0000 : 16'hFFF8));
    lat_a.push_back(33);
  endtask

  // Pattern 2: strictly increasing, so each max is the window's bottom-right element.
  task automatic load_p2();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++)
        for (int x = 0; x < 4; x++)
          if_a.in_feature[c][r][x] = 16'(16'h0100 + c * 16 + r * 4 + x);
  endtask

  task automatic push_p2();
    exp_a.push_back(mk("p2_c0_00", 0, 0, 0, 16'h0105));
    exp_a.push_back(mk("p2_c0_01", 0, 0, 1, 16'h0107));
    exp_a.push_back(mk("p2_c0_10", 0, 1, 0, 16'h010D));
    exp_a.push_back(mk("p2_c0_11", 0, 1, 1, 16'h010F));
    exp_a.push_back(mk("p2_c1_00", 1, 0, 0, 16'h0115));
    exp_a.push_back(mk("p2_c1_01", 1, 0, 1, 16'h0117));
    exp_a.push_back(mk("p2_c1_10", 1, 1, 0, 16'h011D));
    exp_a.push_back(mk("p2_c1_11", 1, 1, 1, 16'h011F));
    lat_a.push_back(33);
  endtask

  task automatic start_a();
    if_a.start = 1'b1;
    @(posedge clk);
    #1 t0_a = cyc;
    @(negedge clk);
    if_a.start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (!if_a.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!if_a.done) chk("a_done_timeout", 32'(if_a.done), 1);
  endtask

  task automatic chk_a_reset(input string tag);
    logic any_nz = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 2; r++)
        for (int x = 0; x < 2; x++)
          if (if_a.out_feature[c][r][x] !== 16'h0000) any_nz = 1'b1;
    chk({tag, "_busy"}, 32'(if_a.busy), 0);
    chk({tag, "_done"}, 32'(if_a.done), 0);
    chk({tag, "_out_nonzero"}, 32'(any_nz), 0);
  endtask

  // Monitor: on each done pulse, check latency, busy length and the queued outputs.
  initial begin
    int   bc_a = 0, bc_b = 0, bc_c = 0;
    int   l;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_a) bc_a = 0;
      else begin
        if (if_a.busy) bc_a++;
        if (if_a.done) begin
          chk("a_done_expected", 32'(lat_a.size() != 0), 1);
          if (lat_a.size() != 0) begin
            l = lat_a.pop_front();
            chk("a_latency", cyc - t0_a, l);
            chk("a_busy_cycles", bc_a, l - 1);
          end
          bc_a = 0;
          while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            chk(e.name, 32'($unsigned(if_a.out_feature[e.ch][e.r][e.c])), 32'(e.val));
          end
        end
      end
      if (rst_b) bc_b = 0;
      else begin
        if (if_b.busy) bc_b++;
        if (if_b.done) begin
          chk("b_done_expected", 32'(lat_b.size() != 0), 1);
          if (lat_b.size() != 0) begin
            l = lat_b.pop_front();
            chk("b_latency", cyc - t0_b, l);
            chk("b_busy_cycles", bc_b, l - 1);
          end
          bc_b = 0;
          while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            chk(e.name, 32'($unsigned(if_b.out_feature[e.ch][e.r][e.c])), 32'(e.val));
          end
        end
      end
      if (rst_c) bc_c = 0;
      else begin
        if (if_c.busy) bc_c++;
        if (if_c.done) begin
          chk("c_done_expected", 32'(lat_c.size() != 0), 1);
          if (lat_c.size() != 0) begin
            l = lat_c.pop_front();
            chk("c_latency", cyc - t0_c, l);
            chk("c_busy_cycles", bc_c, l - 1);
          end
          bc_c = 0;
          while (exp_c.size() > 0) begin
            e = exp_c.pop_front();
            chk(e.name, 32'($unsigned(if_c.out_feature[e.ch][e.r][e.c])), 32'(e.val));
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
    p1 = '{16'h0080, 16'h0280, 16'hFFFD, 16'hFFFF,
           16'h0180, 16'h0100, 16'hFFF9, 16'hFFFE,
           16'hFFFC, 16'h0006, 16'h7FFF, 16'h8000,
           16'hFFFF, 16'h0000, 16'h0000, 16'h0001,
           16'h8000, 16'h8000, 16'h0010, 16'h0020,
           16'h8000, 16'h8000, 16'h0005, 16'h0030,
           16'h0050, 16'h0001, 16'hFFF0, 16'hFFF8,
           16'hFF00, 16'h0002, 16'hFFF1, 16'hFFF4};
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r++)
        for (int x = 0; x < 4; x++)
          if_a.in_feature[c][r][x] = p1[c * 16 + r * 4 + x];
    #1;
    chk_a_reset("init");
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);

    // Run 1: pattern 1 with stray start pulses mid-scan and in the FINISH cycle.
    push_p1("r1");
    start_a();
    repeat (9) @(negedge clk);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    while (cyc < t0_a + 32) @(negedge clk);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    @(negedge clk);
    chk("r1_no_restart_busy", 32'(if_a.busy), 0);
    chk("r1_done_one_cycle", 32'(if_a.done), 0);

    // Run 2, then run 3 started back-to-back one cycle after done.
    push_p1("r2");
    start_a();
    wait_done_a(100);
    #1;
    push_p1("r3");
    start_a();
    wait_done_a(100);
    @(negedge clk);

    // Run 4 abandoned by an asynchronous mid-scan reset; run 5 completes normally.
    load_p2();
    start_a();
    repeat (20) @(negedge clk);
    #2 rst_a = 1'b1;
    #1 chk_a_reset("midrst");
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    push_p2();
    start_a();
    wait_done_a(100);
    @(negedge clk);

    // Default geometry: latency and a few sparse outputs including the last window.
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 28; r++)
        for (int x = 0; x < 28; x++)
          if_b.in_feature[c][r][x] = 16'h0000;
    if_b.in_feature[0][0][1]   = 16'h0007;
    if_b.in_feature[3][10][4]  = 16'h1234;
    if_b.in_feature[7][27][27] = 16'hFFFB;
    if_b.in_feature[7][26][26] = 16'hFFF0;
    if_b.in_feature[7][26][27] = 16'hFFF0;
    if_b.in_feature[7][27][26] = 16'hFFF0;
    exp_b.push_back(mk("b_c0_0_0", 0, 0, 0, 16'h0007));
    exp_b.push_back(mk("b_c3_5_2", 3, 5, 2, 16'h1234));
    exp_b.push_back(mk("b_c7_13_13", 7, 13, 13, RELU ? 16'h0000 : 16'hFFFB));
    exp_b.push_back(mk("b_c7_13_12", 7, 13, 12, 16'h0000));
    lat_b.push_back(6273);
    if_b.start = 1'b1;
    @(posedge clk);
    #1 t0_b = cyc;
    @(negedge clk);
    if_b.start = 1'b0;
    n = 0;
    while (!if_b.done && n < 7000) begin
      @(negedge clk);
      n++;
    end
    if (!if_b.done) chk("b_done_timeout", 32'(if_b.done), 1);
    @(negedge clk);

    // Odd size: trailing row/column hold 0x7FFF and must never be read.
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 5; r++)
        for (int x = 0; x < 5; x++)
          if_c.in_feature[c][r][x] = (r == 4 || x == 4) ? 16'h7FFF : 16'h0001;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 2; r++)
        for (int x = 0; x < 2; x++)
          exp_c.push_back(mk($sformatf("c_c%0d_%0d_%0d", c, r, x), c, r, x, 16'h0001));
    lat_c.push_back(33);
    if_c.start = 1'b1;
    @(posedge clk);
    #1 t0_c = cyc;
    @(negedge clk);
    if_c.start = 1'b0;
    n = 0;
    while (!if_c.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!if_c.done) chk("c_done_timeout", 32'(if_c.done), 1);
    @(negedge clk);
    chk("queues_drained", 32'(exp_a.size() + exp_b.size() + exp_c.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
